cpr_dispatch: RTL and testbench

Write-side counterpart of the N-way merging comparator. It accepts one tagged stream of sub-domain data beats and routes each beat into one of 2**LANE_W per-lane FIFOs. For every lane it counts the beats of each input block and, when the block closes, publishes an info record `{FDSSI, SSI, cnt}` on that lane's info channel. That record is what the merger consumes to size and bound its reads.

---
 rtl/cpr_dispatch.sv | 144 ++++++++++++++
 tb/tb_cpr_dispatch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpr_dispatch.sv
// rtl/cpr_dispatch.sv - routes tagged beats into per-lane FIFOs and publishes per-block info records
// Optional feature macro: CPR_DISPATCH_FORCE_CLOSE_EN (force-close a block at full count, sticky err)

module cpr_dispatch #(
  parameter int LANE_W  = 2,
  parameter int DATA_W  = 24,
  parameter int FDSSI_W = 12,
  parameter int SSI_W   = 8,
  parameter int CNT_W   = 8,
  localparam int N      = 2 ** LANE_W,
  localparam int INFO_W = FDSSI_W + SSI_W + CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [LANE_W-1:0]     s_lane,
  input  logic [FDSSI_W-1:0]    s_fdssi,
  input  logic [SSI_W-1:0]      s_ssi,
  input  logic                  s_last,
  output logic [N-1:0]          wrreq,
  output logic [N*DATA_W-1:0]   data,
  input  logic [N-1:0]          full,
  output logic [N-1:0]          info_tvalid,
  input  logic [N-1:0]          info_tready,
  output logic [N*INFO_W-1:0]   info,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N-1:0]         open_q;
  logic [FDSSI_W-1:0]   hdr_fdssi_q [N];
  logic [SSI_W-1:0]     hdr_ssi_q   [N];
  logic [CNT_W-1:0]     cnt_q       [N];
  logic [DATA_W-1:0]    data_q      [N];
  logic [INFO_W-1:0]    info_q      [N];
  logic [N-1:0]         wrreq_q;
  logic [N-1:0]         info_tvalid_q;

  logic                 lane_open;
  logic [CNT_W-1:0]     lane_cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 close_beat;
  logic                 hold_max;
  logic                 slot_free;
  logic                 accept;
  logic [FDSSI_W-1:0]   rec_fdssi;
  logic [SSI_W-1:0]     rec_ssi;
`ifdef CPR_DISPATCH_FORCE_CLOSE_EN
  logic                 force_close;
  logic                 err_q;
`endif

  // Accept decision and next count for the lane addressed by the current beat
  always_comb begin
    lane_open = open_q[s_lane];
    lane_cnt  = cnt_q[s_lane];
    if (!lane_open) begin
      cnt_next = CNT_ONE;
    end else if (lane_cnt == CNT_MAX) begin
      // Only reachable when a last beat arrives at full count; saturate instead of wrapping to 0
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = lane_cnt + CNT_ONE;
    end
`ifdef CPR_DISPATCH_FORCE_CLOSE_EN
    // The beat that brings the count to its maximum closes the block even without s_last
    force_close = !s_last && (cnt_next == CNT_MAX);
    close_beat  = s_last || force_close;
    hold_max    = 1'b0;
`else
    // At full count only a last beat may enter, so the counter never has to wrap
    close_beat  = s_last;
    hold_max    = lane_open && (lane_cnt == CNT_MAX) && !s_last;
`endif
    slot_free = !info_tvalid_q[s_lane] || info_tready[s_lane];
    s_ready   = !full[s_lane] && !hold_max && (!close_beat || slot_free);
    accept    = s_valid && s_ready;
    rec_fdssi = lane_open ? hdr_fdssi_q[s_lane] : s_fdssi;
    rec_ssi   = lane_open ? hdr_ssi_q[s_lane]   : s_ssi;
  end

  // Per-lane block tracking, FIFO write port and info record holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      open_q        <= '0;
      wrreq_q       <= '0;
      info_tvalid_q <= '0;
      for (int i = 0; i < N; i++) begin
        hdr_fdssi_q[i] <= '0;
        hdr_ssi_q[i]   <= '0;
        cnt_q[i]       <= '0;
        data_q[i]      <= '0;
        info_q[i]      <= '0;
      end
    end else begin
      wrreq_q       <= '0;
      info_tvalid_q <= info_tvalid_q & ~info_tready;
      if (accept) begin
        wrreq_q[s_lane] <= 1'b1;
        data_q[s_lane]  <= s_data;
        cnt_q[s_lane]   <= cnt_next;
        if (!lane_open) begin
          hdr_fdssi_q[s_lane] <= s_fdssi;
          hdr_ssi_q[s_lane]   <= s_ssi;
        end
        if (close_beat) begin
          // A close overrides a same-cycle drain of the previous record
          open_q[s_lane]        <= 1'b0;
          info_q[s_lane]        <= {rec_fdssi, rec_ssi, cnt_next};
          info_tvalid_q[s_lane] <= 1'b1;
        end else begin
          open_q[s_lane] <= 1'b1;
        end
      end
    end
  end

`ifdef CPR_DISPATCH_FORCE_CLOSE_EN
  // Sticky flag recording that at least one block was cut short at full count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept && force_close) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign wrreq       = wrreq_q;
  assign info_tvalid = info_tvalid_q;

  for (genvar g = 0; g < N; g++) begin : g_lane_out
    assign data[g*DATA_W +: DATA_W] = data_q[g];
    assign info[g*INFO_W +: INFO_W] = info_q[g];
  end

endmodule

// File: tb/tb_cpr_dispatch.sv
// tb/tb_cpr_dispatch.sv - scoreboard bench for cpr_dispatch (honours CPR_DISPATCH_FORCE_CLOSE_EN)

module tb_cpr_dispatch;

  localparam int LANE_W  = 2;
  localparam int DATA_W  = 24;
  localparam int FDSSI_W = 12;
  localparam int SSI_W   = 8;
  localparam int CNT_W   = 8;
  localparam int N       = 4;
  localparam int INFO_W  = 28;
  localparam logic [CNT_W-1:0] CMAX = 8'hFF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data;
  logic [LANE_W-1:0]    s_lane;
  logic [FDSSI_W-1:0]   s_fdssi;
  logic [SSI_W-1:0]     s_ssi;
  logic                 s_last;
  logic [N-1:0]         wrreq;
  logic [N*DATA_W-1:0]  data;
  logic [N-1:0]         full;
  logic [N-1:0]         info_tvalid;
  logic [N-1:0]         info_tready;
  logic [N*INFO_W-1:0]  info;
  logic                 err;

  always #5 clk = ~clk;

  cpr_dispatch dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_lane(s_lane), .s_fdssi(s_fdssi), .s_ssi(s_ssi), .s_last(s_last),
    .wrreq(wrreq), .data(data), .full(full), .info_tvalid(info_tvalid),
    .info_tready(info_tready), .info(info), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model state
  logic [N-1:0]        m_open, m_tv, new_rec;
  logic [CNT_W-1:0]    m_cnt  [N];
  logic [FDSSI_W-1:0]  m_fd   [N];
  logic [SSI_W-1:0]    m_ss   [N];
  logic [DATA_W-1:0]   m_data [N];
  logic                m_err, exp_wr_v;
  logic [LANE_W-1:0]   exp_wr_lane;
  logic [DATA_W-1:0]   wq [$];
  logic [INFO_W-1:0]   rq [N][$];

  logic                m_ready, m_close, m_force, m_block, m_acc;
  logic [CNT_W-1:0]    m_nc;
  logic [FDSSI_W-1:0]  m_rec_fd;
  logic [SSI_W-1:0]    m_rec_ss;

  always_comb begin
    m_nc = !m_open[s_lane] ? 8'd1 : (m_cnt[s_lane] == CMAX ? CMAX : m_cnt[s_lane] + 8'd1);
`ifdef CPR_DISPATCH_FORCE_CLOSE_EN
    m_force = !s_last && (m_nc == CMAX);
    m_block = 1'b0;
`else
    m_force = 1'b0;
    m_block = m_open[s_lane] && (m_cnt[s_lane] == CMAX) && !s_last;
`endif
    m_close  = s_last || m_force;
    m_ready  = !full[s_lane] && !m_block && (!m_close || !m_tv[s_lane] || info_tready[s_lane]);
    m_acc    = s_valid && m_ready;
    m_rec_fd = m_open[s_lane] ? m_fd[s_lane] : s_fdssi;
    m_rec_ss = m_open[s_lane] ? m_ss[s_lane] : s_ssi;
  end

  // Model update: push expected writes and records as beats are accepted
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_open <= '0; m_tv <= '0; new_rec <= '0; m_err <= 1'b0;
      exp_wr_v <= 1'b0; exp_wr_lane <= '0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= '0; m_fd[i] <= '0; m_ss[i] <= '0; m_data[i] <= '0;
        rq[i].delete();
      end
      wq.delete();
    end else begin
      exp_wr_v    <= m_acc;
      exp_wr_lane <= s_lane;
      new_rec     <= '0;
      m_tv        <= m_tv & ~info_tready;
      if (m_acc) begin
        wq.push_back(s_data);
        m_data[s_lane] <= s_data;
        m_cnt[s_lane]  <= m_nc;
        if (!m_open[s_lane]) begin
          m_fd[s_lane] <= s_fdssi;
          m_ss[s_lane] <= s_ssi;
        end
        if (m_close) begin
          rq[s_lane].push_back({m_rec_fd, m_rec_ss, m_nc});
          m_tv[s_lane]    <= 1'b1;
          new_rec[s_lane] <= 1'b1;
          m_open[s_lane]  <= 1'b0;
        end else begin
          m_open[s_lane] <= 1'b1;
        end
        if (m_force) m_err <= 1'b1;
      end
    end
  end

  // Monitor: pop and compare on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      check("wrreq", wrreq, exp_wr_v ? ({{(N-1){1'b0}}, 1'b1} << exp_wr_lane) : {N{1'b0}});
      if (exp_wr_v) begin
        check("wq_nonempty", wq.size() != 0, 1'b1);
        if (wq.size() != 0) begin
          check("wr_data", data[exp_wr_lane*DATA_W +: DATA_W], wq[0]);
          void'(wq.pop_front());
        end
      end
      check("info_tvalid", info_tvalid, m_tv);
      check("err", err, m_err);
      for (int i = 0; i < N; i++) begin
        check("data_hold", data[i*DATA_W +: DATA_W], m_data[i]);
        if (new_rec[i]) begin
          check("info_align", wrreq[i], 1'b1);
          check("rq_nonempty", rq[i].size() != 0, 1'b1);
          if (rq[i].size() != 0) begin
            check("info_rec", info[i*INFO_W +: INFO_W], rq[i][0]);
            void'(rq[i].pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int lane, input logic [DATA_W-1:0] d, input logic [FDSSI_W-1:0] fd,
                      input logic [SSI_W-1:0] ss, input logic last, input int max_cyc,
                      input int pulse, output bit acc, output int waits);
    @(negedge clk);
    s_valid = 1'b1; s_lane = lane[LANE_W-1:0]; s_data = d;
    s_fdssi = fd; s_ssi = ss; s_last = last;
    if (pulse >= 0) info_tready[pulse] = 1'b1;
    acc = 1'b0;
    waits = 0;
    for (int c = 0; c < max_cyc; c++) begin
      bit e;
      #1;
      e = m_ready;
      check("s_ready", s_ready, e);
      @(posedge clk);
      if (e) begin
        acc = 1'b1;
        break;
      end
      waits++;
      if (c != max_cyc - 1) @(negedge clk);
    end
    #1;
    s_valid = 1'b0;
    if (pulse >= 0) info_tready[pulse] = 1'b0;
  endtask

  task automatic beat(input int lane, input logic [DATA_W-1:0] d, input logic [FDSSI_W-1:0] fd,
                      input logic [SSI_W-1:0] ss, input logic last);
    bit acc;
    int w;
    send(lane, d, fd, ss, last, 20, -1, acc, w);
    check("beat_accept", acc, 1'b1);
    check("beat_no_bubble", w, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    int w;
    rst = 1'b1; s_valid = 1'b0; s_lane = '0; s_data = '0; s_fdssi = '0; s_ssi = '0;
    s_last = 1'b0; full = '0; info_tready = '1;
    #1 rst = 1'b0;
    #2;
    check("rst_wrreq", wrreq, 0);
    check("rst_tvalid", info_tvalid, 0);
    check("rst_info", info, 0);
    check("rst_data", data, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Four-beat block on lane 2; later headers must be ignored
    info_tready[2] = 1'b0;
    for (int k = 0; k < 4; k++)
      beat(2, 24'hA00000 + k, (k == 0) ? 12'h123 : 12'hE00 + k, (k == 0) ? 8'h45 : 8'hE0 + k, k == 3);
    @(negedge clk);
    check("t1_info", info[2*INFO_W +: INFO_W], {12'h123, 8'h45, 8'd4});
    check("t1_tvalid", info_tvalid[2], 1'b1);
    info_tready[2] = 1'b1;

    // Lanes 0 and 1 interleaved beat by beat
    for (int k = 0; k < 3; k++) begin
      beat(0, 24'hB00000 + k, (k == 0) ? 12'h010 : 12'hFFF, (k == 0) ? 8'h01 : 8'hFF, k == 2);
      beat(1, 24'hB10000 + k, (k == 0) ? 12'h020 : 12'hFFE, (k == 0) ? 8'h02 : 8'hFE, k == 2);
    end

    // FIFO full on lane 1 stalls the stream
    full[1] = 1'b1;
    send(1, 24'hC00000, 12'h200, 8'h20, 1'b0, 3, -1, acc, w);
    check("t3_stall", acc, 1'b0);
    full[1] = 1'b0;
    beat(1, 24'hC00000, 12'h200, 8'h20, 1'b0);
    beat(1, 24'hC00001, 12'h201, 8'h21, 1'b1);

    // Info slot busy on lane 3, freed by a same-cycle tready pulse
    info_tready[3] = 1'b0;
    beat(3, 24'hD00000, 12'h3A1, 8'h31, 1'b1);
    send(3, 24'hD00001, 12'h3B2, 8'h32, 1'b1, 3, -1, acc, w);
    check("t4_stall", acc, 1'b0);
    send(3, 24'hD00001, 12'h3B2, 8'h32, 1'b1, 3, 3, acc, w);
    check("t4_accept", acc, 1'b1);
    check("t4_wait", w, 0);
    @(negedge clk);
    check("t4_info", info[3*INFO_W +: INFO_W], {12'h3B2, 8'h32, 8'd1});
    check("t4_tvalid", info_tvalid[3], 1'b1);

    // Count limit on lane 0
    info_tready[0] = 1'b0;
    for (int k = 0; k < 255; k++)
      beat(0, 24'hE00000 + k, (k == 0) ? 12'h5A5 : 12'h000, (k == 0) ? 8'h5B : 8'h00, 1'b0);
`ifdef CPR_DISPATCH_FORCE_CLOSE_EN
    @(negedge clk);
    check("t5_force_info", info[0 +: INFO_W], {12'h5A5, 8'h5B, 8'hFF});
    check("t5_err", err, 1'b1);
    info_tready[0] = 1'b1;
    beat(0, 24'hF00000, 12'h6C6, 8'h6D, 1'b1);
    @(negedge clk);
    check("t5_new_block", info[0 +: INFO_W], {12'h6C6, 8'h6D, 8'd1});
    check("t5_err_sticky", err, 1'b1);
`else
    send(0, 24'hE000FF, 12'h000, 8'h00, 1'b0, 3, -1, acc, w);
    check("t5_hold", acc, 1'b0);
    check("t5_err0", err, 1'b0);
    send(0, 24'hE000FF, 12'h000, 8'h00, 1'b1, 3, -1, acc, w);
    check("t5_last_accept", acc, 1'b1);
    @(negedge clk);
    check("t5_sat_info", info[0 +: INFO_W], {12'h5A5, 8'h5B, 8'hFF});
    info_tready[0] = 1'b1;
`endif

    // Reset with a half-open block on lane 0 and a pending record on lane 3
    beat(0, 24'h900000, 12'h7E7, 8'h77, 1'b0);
    beat(0, 24'h900001, 12'h7E8, 8'h78, 1'b0);
    @(negedge clk);
    check("t6_pending", info_tvalid[3], 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_wrreq", wrreq, 0);
    check("t6_tvalid", info_tvalid, 0);
    check("t6_info", info, 0);
    check("t6_data", data, 0);
    check("t6_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    beat(0, 24'h910000, 12'h8F8, 8'h88, 1'b1);
    @(negedge clk);
    check("t6_restart", info[0 +: INFO_W], {12'h8F8, 8'h88, 8'd1});

    info_tready = '1;
    repeat (3) @(negedge clk);
    check("wq_drained", wq.size(), 0);
    for (int i = 0; i < N; i++) check("rq_drained", rq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
